// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ROM download loader: FSM states, FIFO entry layout
// and SDRAM byte-lane masks.
package jtframe_prog_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      POST  = 2'd3
   } state_t;

   // One buffered byte write: word address, byte value and active-low lane mask
   typedef struct packed {
      logic [21:0] addr;
      logic [7:0]  data;
      logic [1:0]  mask;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // Active-low byte enables: even byte goes to the low lane, odd to the high lane
   localparam logic [1:0] MASK_LO = 2'b10;
   localparam logic [1:0] MASK_HI = 2'b01;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Single-clock FIFO buffering download bytes ahead of the SDRAM write stage.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module jtframe_prog_fifo #(
   parameter int FIFO_AW = 2,
   parameter int DW      = 32
) (
   input  logic          clk_sys,
   input  logic          RESET,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [DW-1:0]      mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   cnt;
   logic               do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = cnt[FIFO_AW];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping, cleared asynchronously
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         cnt <= cnt + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
      end
   end

   // Storage array; contents are meaningless while the FIFO is empty
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jtframe_prog_loader.sv
// Turns the HPS ioctl byte stream into masked 16-bit SDRAM programming writes.
// Header bytes are skipped, bytes are buffered so SDRAM stalls never block the
// HPS, and dwnld_busy keeps the game in reset until all bytes are committed
// plus a settle period.
module jtframe_prog_loader
   import jtframe_prog_pkg::*;
#(
   parameter int HEADER      = 0,
   parameter int FIFO_AW     = 2,
   parameter int POST_CYCLES = 256
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        downloading,
   input  logic        ioctl_wr,
   input  logic [21:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        prog_rdy,
   output logic [21:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic [1:0]  prog_mask,
   output logic        prog_we,
   output logic        dwnld_busy,
   output logic        overflow
);

   state_t      state, state_nx;
   logic [15:0] cnt, cnt_nx;
   logic        dl_l, dl_rise;
   logic        hdr_ok, push_req, pop;
   logic        fifo_empty, fifo_full;
   logic [21:0] offset;
   entry_t      fifo_din, fifo_dout;

   assign dl_rise = downloading & ~dl_l;
   assign offset  = ioctl_addr - 22'(HEADER);

   if (HEADER == 0) begin : g_nohdr
      assign hdr_ok = 1'b1;
   end else begin : g_hdr
      assign hdr_ok = ioctl_addr >= 22'(HEADER);
   end

   assign push_req = ioctl_wr & hdr_ok & (state == LOAD);
   // Load the output stage whenever it is free or retiring this cycle
   assign pop      = ~fifo_empty & (~prog_we | prog_rdy);

   // Split the file offset into word address and byte-lane mask
   always_comb begin
      fifo_din      = '0;
      fifo_din.addr = {1'b0, offset[21:1]};
      fifo_din.data = ioctl_data;
      fifo_din.mask = offset[0] ? MASK_HI : MASK_LO;
   end

   jtframe_prog_fifo #(
      .FIFO_AW (FIFO_AW),
      .DW      (ENTRY_W)
   ) u_fifo (
      .clk_sys (clk_sys),
      .RESET   (RESET),
      .push    (push_req),
      .pop     (pop),
      .din     (fifo_din),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Output stage: hold the write until the SDRAM accepts it, chain back-to-back
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         prog_we   <= 1'b0;
         prog_addr <= '0;
         prog_data <= '0;
         prog_mask <= '0;
      end else if (pop) begin
         prog_we   <= 1'b1;
         prog_addr <= fifo_dout.addr;
         prog_data <= fifo_dout.data;
         prog_mask <= fifo_dout.mask;
      end else if (prog_rdy) begin
         prog_we   <= 1'b0;
      end
   end

   // Sticky record of a byte lost to a full FIFO
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET)                             overflow <= 1'b0;
      else if (push_req & fifo_full & ~pop)  overflow <= 1'b1;
   end

   // State register, settle counter and downloading edge detector
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= '0;
         dl_l  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         dl_l  <= downloading;
      end
   end

   // Next-state logic; a new download window always wins over drain/settle
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      dwnld_busy = (state != IDLE);
      case (state)
         IDLE:  if (dl_rise) state_nx = LOAD;
         LOAD:  if (!downloading) state_nx = DRAIN;
         DRAIN: begin
            if (dl_rise) begin
               state_nx = LOAD;
            end else if (fifo_empty && !prog_we) begin
               state_nx = POST;
               cnt_nx   = 16'(POST_CYCLES - 1);
            end
         end
         POST: begin
            if (dl_rise)           state_nx = LOAD;
            else if (cnt == '0)    state_nx = IDLE;
            else                   cnt_nx   = cnt - 16'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_jtframe_prog_loader.sv
// Directed bench for jtframe_prog_loader with a write scoreboard.
module tb_jtframe_prog_loader;

   localparam int HEADER = 2;

   logic        clk_sys = 1'b0;
   logic        RESET, downloading, ioctl_wr, prog_rdy;
   logic [21:0] ioctl_addr, prog_addr;
   logic [7:0]  ioctl_data, prog_data;
   logic [1:0]  prog_mask;
   logic        prog_we, dwnld_busy, overflow;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   jtframe_prog_loader #(
      .HEADER      (HEADER),
      .FIFO_AW     (2),
      .POST_CYCLES (256)
   ) dut (
      .clk_sys     (clk_sys),
      .RESET       (RESET),
      .downloading (downloading),
      .ioctl_wr    (ioctl_wr),
      .ioctl_addr  (ioctl_addr),
      .ioctl_data  (ioctl_data),
      .prog_rdy    (prog_rdy),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_mask   (prog_mask),
      .prog_we     (prog_we),
      .dwnld_busy  (dwnld_busy),
      .overflow    (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected write word {addr22, data8, mask2} for a byte at file address a
   function automatic logic [31:0] model(input logic [21:0] a, input logic [7:0] d);
      logic [21:0] off;
      off = a - 22'(HEADER);
      return {off >> 1, d, (off[0] ? 2'b01 : 2'b10)};
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send(input logic [21:0] a, input logic [7:0] d, input bit keep);
      if (keep) exp_q.push_back(model(a, d));
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_data = d;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk_sys);
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
      tick();
   endtask

   // Scoreboard monitor: compare each retiring write and check hold stability
   logic        hold_v = 1'b0;
   logic [31:0] hold_val;
   always @(negedge clk_sys) begin
      if (RESET) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v && prog_we)
            check("hold_stable", {prog_addr, prog_data, prog_mask}, hold_val);
         if (prog_we && prog_rdy) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               failures++;
               $error("FAIL spurious_write observed=%0h expected=none", {prog_addr, prog_data, prog_mask});
            end
            if (exp_q.size() != 0)
               check("write", {prog_addr, prog_data, prog_mask}, exp_q.pop_front());
         end
         hold_v   = prog_we && !prog_rdy;
         hold_val = {prog_addr, prog_data, prog_mask};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      int  cnt;
      bit  all_busy;

      RESET = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_data = '0; prog_rdy = 1'b1;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_we",   prog_we, 0);
      check("rst_busy", dwnld_busy, 0);
      check("rst_ovf",  overflow, 0);
      check("rst_addr", prog_addr, 0);
      check("rst_data", prog_data, 0);
      check("rst_mask", prog_mask, 0);
      tick();
      RESET = 1'b0;
      tick(); tick();

      // Download window opens
      downloading = 1'b1;
      tick();
      @(negedge clk_sys);
      check("busy_rise", dwnld_busy, 1);
      tick();

      // Header filter: addr 0,1 skipped, 2,3 become word 0 low/high
      send(22'd0, 8'h11, 0);
      send(22'd1, 8'h22, 0);
      send(22'd2, 8'hA1, 1);
      send(22'd3, 8'hB2, 1);
      wait_drain(20);

      // First-write latency with empty FIFO
      exp_q.push_back(model(22'h12, 8'h5A));
      ioctl_wr = 1'b1; ioctl_addr = 22'h12; ioctl_data = 8'h5A;
      tick();
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      check("lat_edge_n", prog_we, 0);
      @(negedge clk_sys);
      check("lat_edge_n1", prog_we, 1);
      tick();
      send(22'h13, 8'hC3, 1);
      wait_drain(20);

      // Overflow: rdy low, 6 bytes, 5 retained
      prog_rdy = 1'b0;
      for (int i = 0; i < 6; i++)
         send(22'(4 + i), 8'(8'h30 + i), i < 5);
      repeat (14) tick();
      @(negedge clk_sys);
      check("ovf_set",  overflow, 1);
      check("ovf_we",   prog_we, 1);
      check("ovf_head", prog_addr, 1);
      tick();
      prog_rdy = 1'b1;
      wait_drain(30);

      // Drain and settle: busy lasts 257 sampled cycles from the last retirement
      send(22'h20, 8'h01, 1);
      send(22'h21, 8'h02, 1);
      send(22'h22, 8'h03, 1);
      downloading = 1'b0;
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (prog_we && n < 50);
      check("drain_we_fall", prog_we, 0);
      cnt = 0;
      while (dwnld_busy && cnt < 400) begin
         cnt++;
         @(negedge clk_sys);
      end
      check("post_len", cnt, 257);
      check("ovf_sticky", overflow, 1);
      check("exp_empty_post", exp_q.size(), 0);
      tick();

      // Writes while idle are ignored
      send(22'h30, 8'h77, 0);
      repeat (3) tick();
      @(negedge clk_sys);
      check("idle_we", prog_we, 0);
      check("idle_busy", dwnld_busy, 0);
      tick();

      // Re-rise during POST keeps busy continuously high
      downloading = 1'b1;
      tick();
      send(22'h40, 8'h10, 1);
      downloading = 1'b0;
      wait_drain(20);
      all_busy = 1'b1;
      repeat (60) begin
         @(negedge clk_sys);
         all_busy &= dwnld_busy;
      end
      tick();
      downloading = 1'b1;
      repeat (20) begin
         @(negedge clk_sys);
         all_busy &= dwnld_busy;
      end
      check("busy_continuous", all_busy, 1);
      tick();
      send(22'h41, 8'h99, 1);
      wait_drain(20);

      // Reset mid-download with queued bytes
      prog_rdy = 1'b0;
      send(22'h50, 8'hE0, 0);
      send(22'h51, 8'hE1, 0);
      send(22'h52, 8'hE2, 0);
      @(negedge clk_sys);
      check("pre_rst_we", prog_we, 1);
      tick();
      RESET = 1'b1;
      downloading = 1'b0;
      @(negedge clk_sys);
      check("mid_rst_we",   prog_we, 0);
      check("mid_rst_busy", dwnld_busy, 0);
      check("mid_rst_ovf",  overflow, 0);
      tick();
      RESET = 1'b0;
      prog_rdy = 1'b1;
      repeat (10) @(negedge clk_sys);
      check("post_rst_we",   prog_we, 0);
      check("post_rst_busy", dwnld_busy, 0);
      tick();

      // downloading already high at reset release counts as a rising edge
      RESET = 1'b1;
      downloading = 1'b1;
      tick();
      RESET = 1'b0;
      @(negedge clk_sys);
      check("rel_busy0", dwnld_busy, 0);
      @(negedge clk_sys);
      check("rel_load", dwnld_busy, 1);
      tick();
      send(22'h60, 8'h5C, 1);
      wait_drain(20);
      downloading = 1'b0;
      tick();

      check("final_queue", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
